spi_tx_buffer: RTL and testbench



---
 rtl/spi_tx_buffer.sv | 81 ++++++++
 tb/tb_spi_tx_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_buffer.sv
// SPI responder transmitter: one-entry holding register feeding an MSB-first
// shifter on DO, with 0xFF idle fill whenever no response byte is queued.
module spi_tx_buffer #(
    parameter int             W            = 8,
    parameter logic [W-1:0]   IDLE_PATTERN = 8'hFF
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         CS,
    input  logic [W-1:0] Data,
    input  logic         Valid,
    output logic         Ready,
    output logic         DO,
    output logic         Busy,
    output logic         Sent,
    output logic         Underrun
);

    localparam int             CW   = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  LAST = CW'(W - 1);

    logic [W-1:0]  hold;
    logic          hold_full;
    logic [W-2:0]  sh;
    logic [CW-1:0] cnt;
    logic          is_data;
    logic [W-1:0]  src;

    assign Ready = !hold_full;
    assign Busy  = is_data;
    assign src   = hold_full ? hold : IDLE_PATTERN;

    // The handshake and the boundary load never touch hold_full on the same
    // edge: an accept needs it clear, a load needs it set.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold      <= '0;
            hold_full <= 1'b0;
            sh        <= '1;
            cnt       <= '0;
            is_data   <= 1'b0;
            DO        <= 1'b1;
            Sent      <= 1'b0;
            Underrun  <= 1'b0;
        end else begin
            if (Valid && Ready) begin
                hold      <= Data;
                hold_full <= 1'b1;
            end

            if (CS) begin
                DO       <= 1'b1;
                sh       <= '1;
                cnt      <= '0;
                is_data  <= 1'b0;
                Sent     <= 1'b0;
                Underrun <= 1'b0;
            end else if (cnt == '0) begin
                DO   <= src[W-1];
                sh   <= src[W-2:0];
                cnt  <= CW'(1);
                Sent <= 1'b0;
                if (hold_full) begin
                    hold_full <= 1'b0;
                    is_data   <= 1'b1;
                end else begin
                    is_data <= 1'b0;
                    // Controller raised Valid too late to keep the response gapless.
                    if (is_data && Valid)
                        Underrun <= 1'b1;
                end
            end else begin
                DO   <= sh[W-2];
                sh   <= {sh[W-3:0], 1'b1};
                cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
                Sent <= (cnt == LAST) && is_data;
            end
        end
    end

endmodule

// File: tb/tb_spi_tx_buffer.sv
// Bench for spi_tx_buffer: directed scenarios plus a random run, each edge
// checked against a byte/bit-position model of the expected MISO stream.
module tb_spi_tx_buffer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cs;
    logic         valid;
    logic [W-1:0] data;
    logic         ready;
    logic         dout;
    logic         busy;
    logic         sent;
    logic         underrun;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    // Model: pending bytes, byte on the wire, and bit position within it.
    logic [7:0]  m_pend[$];
    logic [7:0]  m_cur;
    int          m_pos;
    logic        m_is_data;
    logic        m_do;
    logic        m_sent;
    logic        m_underrun;
    logic        m_accepted;

    logic [31:0] do_hist;
    int          sent_edge;
    int          sent_total;
    int          nxt;
    logic [7:0]  stream [3];

    always #5 clk = ~clk;

    spi_tx_buffer #(.W(W), .IDLE_PATTERN(8'hFF)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .CS       (cs),
        .Data     (data),
        .Valid    (valid),
        .Ready    (ready),
        .DO       (dout),
        .Busy     (busy),
        .Sent     (sent),
        .Underrun (underrun)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) begin
            pass_count++;
        end else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check_output(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic model_reset();
        m_pend.delete();
        m_cur      = 8'hFF;
        m_pos      = 0;
        m_is_data  = 1'b0;
        m_do       = 1'b1;
        m_sent     = 1'b0;
        m_underrun = 1'b0;
        m_accepted = 1'b0;
    endtask

    task automatic model_step(input logic c, input logic v, input logic [7:0] d);
        m_accepted = v && (m_pend.size() == 0);
        if (c) begin
            m_do       = 1'b1;
            m_pos      = 0;
            m_is_data  = 1'b0;
            m_sent     = 1'b0;
            m_underrun = 1'b0;
        end else if (m_pos == 0) begin
            if (m_pend.size() > 0) begin
                m_cur     = m_pend.pop_front();
                m_is_data = 1'b1;
            end else begin
                if (m_is_data && v)
                    m_underrun = 1'b1;
                m_cur     = 8'hFF;
                m_is_data = 1'b0;
            end
            m_do   = m_cur[7];
            m_pos  = 1;
            m_sent = 1'b0;
        end else begin
            m_do   = m_cur[3'(7 - m_pos)];
            m_sent = (m_pos == 7) && m_is_data;
            m_pos  = (m_pos + 1) % 8;
        end
        if (m_accepted)
            m_pend.push_back(d);
    endtask

    task automatic compare_model();
        check_bit("DO", dout, m_do);
        check_bit("Ready", ready, m_pend.size() == 0);
        check_bit("Busy", busy, m_is_data);
        check_bit("Sent", sent, m_sent);
        check_bit("Underrun", underrun, m_underrun);
    endtask

    task automatic apply_stimulus(input logic c, input logic v, input logic [7:0] d);
        cs    = c;
        valid = v;
        data  = d;
    endtask

    // One clock: inputs captured as the DUT sees them, outputs checked at negedge.
    task automatic tick();
        logic       c;
        logic       v;
        logic [7:0] d;
        c = cs;
        v = valid;
        d = data;
        @(posedge clk);
        model_step(c, v, d);
        @(negedge clk);
        compare_model();
        do_hist = {do_hist[30:0], dout};
        if (sent)
            sent_total++;
    endtask

    initial begin
        stream[0] = 8'h00;
        stream[1] = 8'hFF;
        stream[2] = 8'h3C;
        do_hist    = '0;
        sent_total = 0;
        apply_stimulus(1'b1, 1'b0, 8'h00);
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_bit("reset DO", dout, 1'b1);
        check_bit("reset Ready", ready, 1'b1);
        check_bit("reset Busy", busy, 1'b0);
        check_bit("reset Sent", sent, 1'b0);
        check_bit("reset Underrun", underrun, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] idle fill");
        apply_stimulus(1'b0, 1'b0, 8'h00);
        repeat (16) tick();
        check_output("idle bits", {16'b0, do_hist[15:0]}, 32'h0000FFFF);
        check_output("idle sent pulses", sent_total, 0);

        $display("[TB] preload 0xA5 while deselected");
        apply_stimulus(1'b1, 1'b1, 8'hA5);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00);
        sent_edge = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (sent)
                sent_edge = i;
            check_bit("A5 busy", busy, 1'b1);
            if (i >= 2)
                check_bit("A5 ready", ready, 1'b1);
        end
        check_output("A5 bits", {24'b0, do_hist[7:0]}, 32'h000000A5);
        check_output("A5 sent edge", sent_edge, 8);
        repeat (8) tick();
        check_output("A5 trailing fill", {24'b0, do_hist[7:0]}, 32'h000000FF);

        $display("[TB] back-to-back stream");
        apply_stimulus(1'b1, 1'b1, stream[0]);
        tick();
        nxt  = 1;
        data = stream[nxt];
        nxt++;
        cs = 1'b0;
        repeat (24) begin
            tick();
            if (m_accepted) begin
                if (nxt < 3) begin
                    data = stream[nxt];
                    nxt++;
                end else begin
                    valid = 1'b0;
                end
            end
        end
        check_output("stream bits", {8'b0, do_hist[23:0]}, 32'h0000FF3C);
        check_bit("stream underrun", underrun, 1'b0);
        tick();
        check_bit("stream end underrun", underrun, 1'b0);

        $display("[TB] late controller");
        apply_stimulus(1'b1, 1'b1, 8'h12);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00);
        repeat (8) tick();
        apply_stimulus(1'b0, 1'b1, 8'h34);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00);
        repeat (15) tick();
        check_output("late bits", {8'b0, do_hist[23:0]}, 32'h0012FF34);
        check_bit("late underrun set", underrun, 1'b1);
        repeat (4) tick();
        check_bit("late underrun sticky", underrun, 1'b1);
        apply_stimulus(1'b1, 1'b0, 8'h00);
        tick();
        check_bit("late underrun cleared", underrun, 1'b0);

        $display("[TB] deselect mid-byte");
        apply_stimulus(1'b1, 1'b1, 8'hC3);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00);
        tick();
        apply_stimulus(1'b0, 1'b1, 8'h55);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00);
        tick();
        check_output("C3 first bits", {29'b0, do_hist[2:0]}, 32'h6);
        apply_stimulus(1'b1, 1'b0, 8'h00);
        tick();
        check_bit("flush DO", dout, 1'b1);
        check_bit("flush hold kept", ready, 1'b0);
        apply_stimulus(1'b0, 1'b0, 8'h00);
        repeat (8) tick();
        check_output("55 after flush", {24'b0, do_hist[7:0]}, 32'h00000055);

        $display("[TB] random traffic");
        repeat (400) begin
            apply_stimulus($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), 8'($urandom));
            tick();
        end

        $display("[TB] async reset mid-byte");
        apply_stimulus(1'b1, 1'b1, 8'h99);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check_bit("async DO", dout, 1'b1);
        check_bit("async Ready", ready, 1'b1);
        check_bit("async Busy", busy, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) tick();
        check_output("post-reset fill", {24'b0, do_hist[7:0]}, 32'h000000FF);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
